// File: rtl/xfire_bkm_pkg.sv
// Shared definitions for the borrow-save accumulator and the CSD-to-binary stage:
// FSM state encoding and the bit layout of a 2-bit borrow-save digit.
package xfire_bkm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } bs_state_e;

  // Digit i occupies bits [DIG_W*i +: DIG_W]; value = data - sign.
  localparam int DIG_W    = 2;
  localparam int DIG_DATA = 0;
  localparam int DIG_SIGN = 1;

endpackage

// File: rtl/bs_add_bin.sv
// Carry-free row: adds a binary word plus cin into a borrow-save word, one FA per digit.
// Each digit's carry moves only into the next digit's data bit, so delay is independent of W.
module bs_add_bin import xfire_bkm_pkg::*; #(
  parameter int W = 64
) (
  input  logic [2*W-1:0] bs_in,
  input  logic [W-1:0]   bin,
  input  logic           cin,
  output logic [2*W-1:0] bs_out
);

  // dnew[i] is the data bit landing in digit i: cin for digit 0, carry of digit i-1 otherwise.
  logic [W-1:0] dnew;
  assign dnew[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_dig
    logic d, ns, t;
    assign d  = bs_in[DIG_W*i + DIG_DATA];
    assign ns = ~bs_in[DIG_W*i + DIG_SIGN];
    assign t  = d ^ bin[i] ^ ns;
    assign bs_out[DIG_W*i + DIG_SIGN] = ~t;
    assign bs_out[DIG_W*i + DIG_DATA] = dnew[i];
    if (i < W - 1) begin : g_cy
      assign dnew[i+1] = (d & bin[i]) | (d & ns) | (bin[i] & ns);
    end
  end

endmodule

// File: rtl/bs_acc.sv
// Borrow-save accumulator: start clears, accepted operands are added (or subtracted
// when BS_ACC_SUB_EN is defined), result is held on acc until out_ready.
module bs_acc import xfire_bkm_pkg::*; #(
  parameter int W = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   b,
`ifdef BS_ACC_SUB_EN
  input  logic           sub,
`endif
  input  logic           last,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] acc
);

  bs_state_e      state_q, state_d;
  logic [2*W-1:0] acc_q, acc_nxt;
  logic           accept, sub_w;

`ifdef BS_ACC_SUB_EN
  assign sub_w = sub;
`else
  assign sub_w = 1'b0;
`endif

  assign accept = in_valid & in_ready;

  // Subtract as add of ~b with cin=1.
  bs_add_bin #(.W(W)) u_row (
    .bs_in  (acc_q),
    .bin    (sub_w ? ~b : b),
    .cin    (sub_w),
    .bs_out (acc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_ACC;
      ST_ACC: begin
        in_ready = 1'b1;
        if (in_valid && last) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && start) acc_q <= '0;
      else if (accept)                 acc_q <= acc_nxt;
    end
  end

  assign acc = acc_q;

endmodule
